// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter serialising icache and dcache line transactions onto one memory port
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic [DATA_W-1:0] req0_data_o,
  output logic              req0_ack_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic [DATA_W-1:0] req1_data_o,
  output logic              req1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       cnt0_o,
  output logic [31:0]       cnt1_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;
  logic [1:0] state;
  logic       last;
  logic       g1;
  assign g1          = req1_enable_i & (~req0_enable_i | ~last);
  assign req0_ack_o  = mem_ack_i & (state == BUSY0);
  assign req1_ack_o  = mem_ack_i & (state == BUSY1);
  assign req0_data_o = (state == BUSY0) ? mem_data_i : '0;
  assign req1_data_o = (state == BUSY1) ? mem_data_i : '0;
  // grant in IDLE capturing the winner's operands, release on memory ack and count completions
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      last         <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      cnt0_o       <= '0;
      cnt1_o       <= '0;
    end else if (state == IDLE) begin
      if (req0_enable_i | req1_enable_i) begin
        state        <= g1 ? BUSY1 : BUSY0;
        last         <= g1;
        mem_enable_o <= 1'b1;
        mem_write_o  <= g1 ? req1_write_i : req0_write_i;
        mem_addr_o   <= g1 ? req1_addr_i : req0_addr_i;
        mem_data_o   <= g1 ? req1_data_i : req0_data_i;
      end
    end else if (mem_ack_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      if (state == BUSY0 && cnt0_o != '1) cnt0_o <= cnt0_o + 32'd1;
      if (state == BUSY1 && cnt1_o != '1) cnt1_o <= cnt1_o + 32'd1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         req0_enable_i = 1'b0, req0_write_i = 1'b0;
  logic [31:0]  req0_addr_i = '0;
  logic [255:0] req0_data_i = '0, req0_data_o;
  logic         req0_ack_o;
  logic         req1_enable_i = 1'b0, req1_write_i = 1'b0;
  logic [31:0]  req1_addr_i = '0;
  logic [255:0] req1_data_i = '0, req1_data_o;
  logic         req1_ack_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [31:0]  cnt0_o, cnt1_o;
  int n_checks = 0;
  int n_fail = 0;
  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i), .req0_addr_i(req0_addr_i),
    .req0_data_i(req0_data_i), .req0_data_o(req0_data_o), .req0_ack_o(req0_ack_o),
    .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i), .req1_addr_i(req1_addr_i),
    .req1_data_i(req1_data_i), .req1_data_o(req1_data_o), .req1_ack_o(req1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .cnt0_o(cnt0_o), .cnt1_o(cnt1_o)
  );
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic pulse_reset();
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
  endtask
  task automatic test_reset();
    #2;
    n_checks++;
    if ({mem_enable_o, mem_write_o, req0_ack_o, req1_ack_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000", {mem_enable_o, mem_write_o, req0_ack_o, req1_ack_o});
    end
    n_checks++;
    if (mem_addr_o !== 32'h0 || mem_data_o !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_mem: addr %h data %h want 0", mem_addr_o, mem_data_o);
    end
    n_checks++;
    if (cnt0_o !== 32'h0 || cnt1_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: cnt0 %h cnt1 %h want 0", cnt0_o, cnt1_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single_read();
    logic [255:0] a5 = {32{8'hA5}};
    req1_enable_i = 1'b1;
    req1_write_i = 1'b0;
    req1_addr_i = 32'h0000_0400;
    @(negedge clk);
    n_checks++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h400 || mem_write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_grant: en %b addr %h wr %b want 1 400 0", mem_enable_o, mem_addr_o, mem_write_o);
    end
    repeat (9) @(negedge clk);
    mem_ack_i = 1'b1;
    mem_data_i = a5;
    #1;
    n_checks++;
    if (req1_ack_o !== 1'b1 || req1_data_o !== a5 || req0_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_ack: ack1 %b ack0 %b data %h want 1 0 %h", req1_ack_o, req0_ack_o, req1_data_o, a5);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    req1_enable_i = 1'b0;
    n_checks++;
    if (mem_enable_o !== 1'b0 || req1_ack_o !== 1'b0 || cnt1_o !== 32'd1 || cnt0_o !== 32'd0) begin
      n_fail++;
      $display("FAIL read_done: en %b ack1 %b cnt1 %0d cnt0 %0d want 0 0 1 0", mem_enable_o, req1_ack_o, cnt1_o, cnt0_o);
    end
  endtask
  task automatic test_tie();
    pulse_reset();
    req0_enable_i = 1'b1;
    req0_addr_i = 32'h100;
    req1_enable_i = 1'b1;
    req1_addr_i = 32'h200;
    @(negedge clk);
    n_checks++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL tie_first: en %b addr %h want 1 200", mem_enable_o, mem_addr_o);
    end
    repeat (2) @(negedge clk);
    mem_ack_i = 1'b1;
    mem_data_i = 256'h11;
    #1;
    n_checks++;
    if (req1_ack_o !== 1'b1 || req0_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_ack1: ack1 %b ack0 %b want 1 0", req1_ack_o, req0_ack_o);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    req1_enable_i = 1'b0;
    n_checks++;
    if (mem_enable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_dead: en %b want 0", mem_enable_o);
    end
    @(negedge clk);
    n_checks++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL tie_second: en %b addr %h want 1 100", mem_enable_o, mem_addr_o);
    end
    mem_ack_i = 1'b1;
    mem_data_i = 256'h22;
    #1;
    n_checks++;
    if (req0_ack_o !== 1'b1 || req0_data_o !== 256'h22 || req1_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_ack0: ack0 %b ack1 %b data %h want 1 0 22", req0_ack_o, req1_ack_o, req0_data_o);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    req0_enable_i = 1'b0;
    n_checks++;
    if (cnt0_o !== 32'd1 || cnt1_o !== 32'd1) begin
      n_fail++;
      $display("FAIL tie_cnt: cnt0 %0d cnt1 %0d want 1 1", cnt0_o, cnt1_o);
    end
  endtask
  task automatic test_contention();
    int p;
    logic [31:0] ea;
    bit seen;
    pulse_reset();
    req0_addr_i = 32'h1000;
    req0_enable_i = 1'b1;
    req1_addr_i = 32'h2000;
    req1_enable_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      p = (k % 2 == 0) ? 1 : 0;
      ea = (p == 1) ? 32'h2000 + 32'(k) * 32'h40 : 32'h1000;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (mem_enable_o === 1'b1) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL rr_timeout: txn %0d got no enable want 1", k);
      end
      n_checks++;
      if (mem_addr_o !== ea) begin
        n_fail++;
        $display("FAIL rr_grant: txn %0d addr %h want %h", k, mem_addr_o, ea);
      end
      repeat (3) begin
        @(negedge clk);
        if (p == 1) req0_addr_i = req0_addr_i ^ 32'h40;
        n_checks++;
        if (mem_addr_o !== ea || mem_enable_o !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_stable: txn %0d addr %h en %b want %h 1", k, mem_addr_o, mem_enable_o, ea);
        end
      end
      mem_ack_i = 1'b1;
      mem_data_i = 256'(k + 1);
      req0_addr_i = 32'h1000;
      #1;
      n_checks++;
      if ({req1_ack_o, req0_ack_o} !== ((p == 1) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rr_ack: txn %0d acks %b want port %0d", k, {req1_ack_o, req0_ack_o}, p);
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (p == 1) req1_enable_i = 1'b0;
      else req0_enable_i = 1'b0;
      @(negedge clk);
      if (k < 4) begin
        if (p == 1) begin
          req1_addr_i = 32'h2000 + 32'(k + 2) * 32'h40;
          req1_enable_i = 1'b1;
        end else req0_enable_i = 1'b1;
      end
    end
    n_checks++;
    if (cnt0_o !== 32'd3 || cnt1_o !== 32'd3) begin
      n_fail++;
      $display("FAIL rr_cnt: cnt0 %0d cnt1 %0d want 3 3", cnt0_o, cnt1_o);
    end
  endtask
  task automatic test_write();
    req0_enable_i = 1'b1;
    req0_write_i = 1'b1;
    req0_addr_i = 32'h80;
    req0_data_i = 256'h1234;
    @(negedge clk);
    n_checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h80 || mem_data_o !== 256'h1234) begin
      n_fail++;
      $display("FAIL wr_grant: en %b wr %b addr %h data %h want 1 1 80 1234", mem_enable_o, mem_write_o, mem_addr_o, mem_data_o);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_write_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_hold: wr %b want 1", mem_write_o);
    end
    mem_ack_i = 1'b1;
    #1;
    n_checks++;
    if (req0_ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ack: ack0 %b want 1", req0_ack_o);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    req0_enable_i = 1'b0;
    req0_write_i = 1'b0;
    n_checks++;
    if (mem_write_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done: wr %b en %b want 0 0", mem_write_o, mem_enable_o);
    end
  endtask
  task automatic test_reset_mid();
    req1_enable_i = 1'b1;
    req1_write_i = 1'b1;
    req1_addr_i = 32'h500;
    req1_data_i = 256'h55;
    @(negedge clk);
    n_checks++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h500) begin
      n_fail++;
      $display("FAIL rstmid_busy: en %b addr %h want 1 500", mem_enable_o, mem_addr_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({mem_enable_o, mem_write_o} !== 2'b0 || mem_addr_o !== 32'h0 || mem_data_o !== 256'h0 || cnt0_o !== 32'h0 || cnt1_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: en %b wr %b addr %h cnt0 %0d cnt1 %0d want all 0", mem_enable_o, mem_write_o, mem_addr_o, cnt0_o, cnt1_o);
    end
    req1_enable_i = 1'b0;
    req1_write_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b1;
    #1;
    n_checks++;
    if ({req0_ack_o, req1_ack_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_stray: acks %b want 00", {req0_ack_o, req1_ack_o});
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    n_checks++;
    if (cnt0_o !== 32'h0 || cnt1_o !== 32'h0 || mem_enable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_cnt: cnt0 %0d cnt1 %0d en %b want 0 0 0", cnt0_o, cnt1_o, mem_enable_o);
    end
    req0_enable_i = 1'b1;
    req0_addr_i = 32'h600;
    @(negedge clk);
    n_checks++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h600) begin
      n_fail++;
      $display("FAIL rstmid_regrant: en %b addr %h want 1 600", mem_enable_o, mem_addr_o);
    end
    mem_ack_i = 1'b1;
    #1;
    n_checks++;
    if (req0_ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ack0: ack0 %b want 1", req0_ack_o);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    req0_enable_i = 1'b0;
    n_checks++;
    if (cnt0_o !== 32'd1) begin
      n_fail++;
      $display("FAIL rstmid_cnt0: cnt0 %0d want 1", cnt0_o);
    end
  endtask
  task automatic test_spurious();
    @(negedge clk);
    mem_ack_i = 1'b1;
    mem_data_i = 256'h77;
    #1;
    n_checks++;
    if ({req0_ack_o, req1_ack_o} !== 2'b00 || req0_data_o !== 256'h0 || req1_data_o !== 256'h0) begin
      n_fail++;
      $display("FAIL spur_ack: acks %b d0 %h d1 %h want 00 0 0", {req0_ack_o, req1_ack_o}, req0_data_o, req1_data_o);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    n_checks++;
    if (cnt0_o !== 32'd1 || cnt1_o !== 32'd0) begin
      n_fail++;
      $display("FAIL spur_cnt: cnt0 %0d cnt1 %0d want 1 0", cnt0_o, cnt1_o);
    end
    req1_enable_i = 1'b1;
    req1_addr_i = 32'h700;
    @(negedge clk);
    req1_enable_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h700) begin
      n_fail++;
      $display("FAIL drop_hold: en %b addr %h want 1 700", mem_enable_o, mem_addr_o);
    end
    @(negedge clk);
    mem_ack_i = 1'b1;
    mem_data_i = 256'h99;
    #1;
    n_checks++;
    if (req1_ack_o !== 1'b1 || req1_data_o !== 256'h99) begin
      n_fail++;
      $display("FAIL drop_ack: ack1 %b data %h want 1 99", req1_ack_o, req1_data_o);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    n_checks++;
    if (cnt1_o !== 32'd1 || mem_enable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_cnt: cnt1 %0d en %b want 1 0", cnt1_o, mem_enable_o);
    end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_contention();
    test_write();
    test_reset_mid();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
